// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtag_pkg
// Purpose  : Shared JTAG command opcodes, IEEE 1149.1 TAP state codes and the
//            TAP state transition helper used by the host and its benches.
// Revision : 1.0
// ============================================================================
package jtag_pkg;

    localparam logic [1:0] OP_TAP_RESET = 2'd0;
    localparam logic [1:0] OP_IR_SCAN   = 2'd1;
    localparam logic [1:0] OP_DR_SCAN   = 2'd2;
    localparam logic [1:0] OP_IDLE_CLK  = 2'd3;

    localparam logic [3:0] TAP_TLR       = 4'hF;
    localparam logic [3:0] TAP_RTI       = 4'hC;
    localparam logic [3:0] TAP_SEL_DR    = 4'h7;
    localparam logic [3:0] TAP_CAP_DR    = 4'h6;
    localparam logic [3:0] TAP_SHIFT_DR  = 4'h2;
    localparam logic [3:0] TAP_EXIT1_DR  = 4'h1;
    localparam logic [3:0] TAP_PAUSE_DR  = 4'h3;
    localparam logic [3:0] TAP_EXIT2_DR  = 4'h0;
    localparam logic [3:0] TAP_UPDATE_DR = 4'h5;
    localparam logic [3:0] TAP_SEL_IR    = 4'h4;
    localparam logic [3:0] TAP_CAP_IR    = 4'hE;
    localparam logic [3:0] TAP_SHIFT_IR  = 4'hA;
    localparam logic [3:0] TAP_EXIT1_IR  = 4'h9;
    localparam logic [3:0] TAP_PAUSE_IR  = 4'hB;
    localparam logic [3:0] TAP_EXIT2_IR  = 4'h8;
    localparam logic [3:0] TAP_UPDATE_IR = 4'hD;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PWRUP = 3'd1,
        S_PRE   = 3'd2,
        S_SHIFT = 3'd3,
        S_POST  = 3'd4,
        S_DONE  = 3'd5
    } seq_state_e;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
        logic [3:0] n;
        case (s)
            TAP_TLR:       n = tms ? TAP_TLR       : TAP_RTI;
            TAP_RTI:       n = tms ? TAP_SEL_DR    : TAP_RTI;
            TAP_SEL_DR:    n = tms ? TAP_SEL_IR    : TAP_CAP_DR;
            TAP_CAP_DR:    n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_SHIFT_DR:  n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_EXIT1_DR:  n = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR:  n = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
            TAP_EXIT2_DR:  n = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
            TAP_UPDATE_DR: n = tms ? TAP_SEL_DR    : TAP_RTI;
            TAP_SEL_IR:    n = tms ? TAP_TLR       : TAP_CAP_IR;
            TAP_CAP_IR:    n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_SHIFT_IR:  n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_EXIT1_IR:  n = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR:  n = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
            TAP_EXIT2_IR:  n = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
            default:       n = tms ? TAP_SEL_DR    : TAP_RTI;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_tck_gen.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tck_gen
// Purpose  : TCK divider; emits one-clk rise/fall strobes aligned with the
//            clk edge on which TCK toggles. TCK is held low while disabled.
// Revision : 1.0
// ============================================================================
module jtag_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic             tck_q;
    logic             term;

    assign term   = en_i && (div_q == DIV_LAST);
    assign rise_o = term && !tck_q;
    assign fall_o = term && tck_q;
    assign tck_o  = tck_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            tck_q <= 1'b0;
        end else if (!en_i) begin
            div_q <= '0;
            tck_q <= 1'b0;
        end else if (term) begin
            div_q <= '0;
            tck_q <= ~tck_q;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/jtag_host.sv
`default_nettype none
// ============================================================================
// Module   : jtag_host
// Purpose  : JTAG initiator turning queued commands into TMS/TDI sequences and
//            capturing TDO from the on-chip TAP.
// Revision : 1.0
// ============================================================================
module jtag_host
    import jtag_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int TCK_DIV = 2,
    parameter int LEN_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               TCK,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    seq_state_e         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [LEN_W-1:0]   len_q, len_d, cnt_q, cnt_d, len_in;
    logic [MAX_LEN-1:0] data_q, data_d, cap_q, cap_d, rsp_q, rsp_d;
    logic               tms_q, tms_d, tdi_q, tdi_d;
    logic               ready_q, ready_d, rsp_valid_q, rsp_valid_d;
    logic               cmd_act_q, cmd_act_d;
    logic [3:0]         tap_q, tap_d;
    logic               tck_en, tck_rise, tck_fall, is_ir, is_scan;

    jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (tck_en),
        .tck_o  (TCK),
        .rise_o (tck_rise),
        .fall_o (tck_fall)
    );

    assign tck_en  = (state_q == S_PWRUP) || (state_q == S_PRE) ||
                     (state_q == S_SHIFT) || (state_q == S_POST);
    assign is_ir   = (op_q == OP_IR_SCAN);
    assign is_scan = (op_q == OP_IR_SCAN) || (op_q == OP_DR_SCAN);

    always_comb begin
        len_in = cmd_len;
        if (cmd_op != OP_IDLE_CLK) begin
            if (cmd_len == '0)
                len_in = LEN_W'(1);
            else if (cmd_len > LEN_MAX)
                len_in = LEN_MAX;
        end
    end

    // TMS/TDI for the next TCK are chosen on each falling strobe; the first
    // TCK's values are loaded at accept while TCK is still low.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        cap_d       = cap_q;
        rsp_d       = rsp_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        cmd_act_d   = cmd_act_q;
        tap_d       = tap_q;

        if (tck_rise) begin
            tap_d = tap_next(tap_q, tms_q);
            if ((tap_q == TAP_SHIFT_IR) || (tap_q == TAP_SHIFT_DR))
                cap_d = cap_q | (MAX_LEN'(TDO) << cnt_q);
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && ready_q) begin
                    ready_d = 1'b0;
                    op_d    = cmd_op;
                    len_d   = len_in;
                    data_d  = cmd_data;
                    cap_d   = '0;
                    cnt_d   = '0;
                    tdi_d   = 1'b0;
                    case (cmd_op)
                        OP_TAP_RESET: begin
                            state_d   = S_PWRUP;
                            cmd_act_d = 1'b1;
                            tms_d     = 1'b1;
                        end
                        OP_IR_SCAN, OP_DR_SCAN: begin
                            state_d = S_PRE;
                            tms_d   = 1'b1;
                        end
                        default: begin
                            tms_d   = 1'b0;
                            state_d = (cmd_len == '0) ? S_DONE : S_SHIFT;
                        end
                    endcase
                end
            end
            S_PWRUP: begin
                if (tck_fall) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    tms_d = (cnt_q < LEN_W'(4));
                    if (cnt_q == LEN_W'(5)) begin
                        cnt_d = '0;
                        tms_d = 1'b0;
                        if (cmd_act_q) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_IDLE;
                            ready_d = 1'b1;
                        end
                    end
                end
            end
            S_PRE: begin
                if (tck_fall) begin
                    if (cnt_q == (is_ir ? LEN_W'(3) : LEN_W'(2))) begin
                        state_d = S_SHIFT;
                        cnt_d   = '0;
                        tms_d   = (len_q == LEN_W'(1));
                        tdi_d   = data_q[0];
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                        tms_d = is_ir && (cnt_q == '0);
                    end
                end
            end
            S_SHIFT: begin
                if (tck_fall) begin
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        cnt_d   = '0;
                        tdi_d   = 1'b0;
                        state_d = is_scan ? S_POST : S_DONE;
                        tms_d   = is_scan;
                    end else begin
                        cnt_d  = cnt_q + LEN_W'(1);
                        data_d = data_q >> 1;
                        tdi_d  = is_scan && data_q[1];
                        tms_d  = is_scan && (cnt_q + LEN_W'(2) == len_q);
                    end
                end
            end
            S_POST: begin
                if (tck_fall) begin
                    tms_d = 1'b0;
                    if (cnt_q == LEN_W'(1)) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            S_DONE: begin
                rsp_valid_d = 1'b1;
                ready_d     = 1'b1;
                rsp_d       = cap_q;
                cmd_act_d   = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_PWRUP;
            op_q        <= OP_TAP_RESET;
            len_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            cap_q       <= '0;
            rsp_q       <= '0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_act_q   <= 1'b0;
            tap_q       <= TAP_TLR;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            cap_q       <= cap_d;
            rsp_q       <= rsp_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_act_q   <= cmd_act_d;
            tap_q       <= tap_d;
        end
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_q;
    assign busy      = (state_q != S_IDLE);
    assign TMS       = tms_q;
    assign TDI       = tdi_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_host
// Purpose  : Self-checking bench for jtag_host with a behavioural TAP observer.
// Revision : 1.0
// ============================================================================
module tb_jtag_host;
    import jtag_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [4:0]  cmd_len = 5'd0;
    logic [15:0] cmd_data = 16'h0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        busy;
    logic        TCK, TMS, TDI, TDO;

    always #5 clk = ~clk;

    jtag_host #(.MAX_LEN(16), .TCK_DIV(2), .LEN_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent TAP observer: follows TMS at each TCK rise and logs activity.
    function automatic logic [3:0] model_next(input logic [3:0] s, input logic m);
        case (s)
            TAP_TLR:       return m ? TAP_TLR       : TAP_RTI;
            TAP_RTI:       return m ? TAP_SEL_DR    : TAP_RTI;
            TAP_SEL_DR:    return m ? TAP_SEL_IR    : TAP_CAP_DR;
            TAP_CAP_DR:    return m ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_SHIFT_DR:  return m ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
            TAP_EXIT1_DR:  return m ? TAP_UPDATE_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR:  return m ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
            TAP_EXIT2_DR:  return m ? TAP_UPDATE_DR : TAP_SHIFT_DR;
            TAP_UPDATE_DR: return m ? TAP_SEL_DR    : TAP_RTI;
            TAP_SEL_IR:    return m ? TAP_TLR       : TAP_CAP_IR;
            TAP_CAP_IR:    return m ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_SHIFT_IR:  return m ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
            TAP_EXIT1_IR:  return m ? TAP_UPDATE_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR:  return m ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
            TAP_EXIT2_IR:  return m ? TAP_UPDATE_IR : TAP_SHIFT_IR;
            default:       return m ? TAP_SEL_DR    : TAP_RTI;
        endcase
    endfunction

    logic [3:0] st = TAP_TLR;
    int tck_cnt = 0;
    int shift_n = 0;
    int tdi_bad = 0;
    bit tms_hist [4096];
    bit tdi_hist [4096];

    always @(posedge TCK or negedge rst_n) begin
        if (!rst_n) begin
            st = TAP_TLR;
        end else begin
            tms_hist[tck_cnt % 4096] = TMS;
            tck_cnt++;
            if (st == TAP_SHIFT_IR || st == TAP_SHIFT_DR) begin
                tdi_hist[shift_n % 4096] = TDI;
                shift_n++;
            end else if (TDI !== 1'b0) begin
                tdi_bad++;
            end
            st = model_next(st, TMS);
        end
    end

    logic [15:0] pat = 16'h0;
    int sh_base = 0;
    int tdo_idx;
    always_comb begin
        tdo_idx = shift_n - sh_base;
        TDO = (tdo_idx >= 0 && tdo_idx < 16) ? pat[tdo_idx[3:0]] : 1'b0;
    end

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  len;
        logic [15:0] data;
        logic [15:0] pat;
        logic [15:0] exp_rsp;
        logic [15:0] exp_tdi;
        int          exp_nsh;
        int          exp_tck;
        logic [31:0] exp_tms;
    } vec_t;

    vec_t vecs [10];

    task automatic reset_vals(input string tag);
        chk({tag, " TCK"}, TCK, 0);
        chk({tag, " TMS"}, TMS, 1);
        chk({tag, " TDI"}, TDI, 0);
        chk({tag, " cmd_ready"}, cmd_ready, 0);
        chk({tag, " rsp_valid"}, rsp_valid, 0);
        chk({tag, " rsp_data"}, rsp_data, 0);
        chk({tag, " busy"}, busy, 1);
    endtask

    task automatic release_and_check(input string tag);
        int tck0, cyc, rsps;
        logic [31:0] tmsw;
        tck0 = tck_cnt;
        rsps = 0;
        cyc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        while (!cmd_ready && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) rsps++;
        end
        chk({tag, " ready after pwrup"}, cmd_ready, 1);
        chk({tag, " pwrup tck count"}, tck_cnt - tck0, 6);
        tmsw = '0;
        for (int k = 0; k < tck_cnt - tck0 && k < 32; k++) tmsw[k] = tms_hist[(tck0 + k) % 4096];
        chk({tag, " pwrup tms"}, tmsw, 32'h1F);
        chk({tag, " pwrup tap"}, st, TAP_RTI);
        chk({tag, " pwrup TCK low"}, TCK, 0);
        chk({tag, " pwrup busy"}, busy, 0);
        chk({tag, " pwrup no rsp"}, rsps, 0);
    endtask

    task automatic run_cmd(input vec_t v, input string tag);
        int tck0, sh0, bad0, cyc, nsh;
        logic got;
        logic [31:0] tmsw;
        logic [15:0] tdiw;
        cyc = 0;
        while (!cmd_ready && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " ready"}, cmd_ready, 1);
        tck0 = tck_cnt; sh0 = shift_n; bad0 = tdi_bad;
        sh_base = shift_n; pat = v.pat;
        cmd_op = v.op; cmd_len = v.len; cmd_data = v.data; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_data = ~v.data; cmd_len = ~v.len; cmd_op = ~v.op;
        chk({tag, " ready drops"}, cmd_ready, 0);
        chk({tag, " busy"}, busy, 1);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) got = 1'b1;
        end
        chk({tag, " rsp_valid seen"}, got, 1);
        chk({tag, " rsp_data"}, rsp_data, v.exp_rsp);
        chk({tag, " ready with rsp"}, cmd_ready, 1);
        chk({tag, " TCK low at rsp"}, TCK, 0);
        @(negedge clk);
        chk({tag, " rsp pulse width"}, rsp_valid, 0);
        chk({tag, " tck count"}, tck_cnt - tck0, v.exp_tck);
        tmsw = '0;
        for (int k = 0; k < tck_cnt - tck0 && k < 32; k++) tmsw[k] = tms_hist[(tck0 + k) % 4096];
        chk({tag, " tms seq"}, tmsw, v.exp_tms);
        nsh = shift_n - sh0;
        chk({tag, " shift bits"}, nsh, v.exp_nsh);
        tdiw = '0;
        for (int k = 0; k < nsh && k < 16; k++) tdiw[k] = tdi_hist[(sh0 + k) % 4096];
        chk({tag, " tdi bits"}, tdiw, v.exp_tdi);
        chk({tag, " tdi idle zero"}, tdi_bad - bad0, 0);
        chk({tag, " tap rti"}, st, TAP_RTI);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rsps, cyc, tck0, sh0;
        logic [15:0] tdiw;

        vecs[0] = '{OP_IR_SCAN,   5'd4,  16'h0005, 16'hFFFF, 16'h000F, 16'h0005, 4,  10, 32'h0000_0183};
        vecs[1] = '{OP_TAP_RESET, 5'd0,  16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 0,  6,  32'h0000_001F};
        vecs[2] = '{OP_IR_SCAN,   5'd4,  16'h000F, 16'h0000, 16'h0000, 16'h000F, 4,  10, 32'h0000_0183};
        vecs[3] = '{OP_DR_SCAN,   5'd8,  16'h00A5, 16'h004A, 16'h004A, 16'h00A5, 8,  13, 32'h0000_0C01};
        vecs[4] = '{OP_IR_SCAN,   5'd0,  16'hFFFF, 16'hFFFF, 16'h0001, 16'h0001, 1,  7,  32'h0000_0033};
        vecs[5] = '{OP_DR_SCAN,   5'd20, 16'h1234, 16'hBEEF, 16'hBEEF, 16'h1234, 16, 21, 32'h000C_0001};
        vecs[6] = '{OP_IDLE_CLK,  5'd3,  16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 0,  3,  32'h0000_0000};
        vecs[7] = '{OP_DR_SCAN,   5'd1,  16'hFFFE, 16'h0000, 16'h0000, 16'h0000, 1,  6,  32'h0000_0019};
        vecs[8] = '{OP_DR_SCAN,   5'd10, 16'h0004, 16'h0155, 16'h0155, 16'h0004, 10, 15, 32'h0000_3001};
        vecs[9] = '{OP_IDLE_CLK,  5'd0,  16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 0,  0,  32'h0000_0000};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_vals("reset");
        release_and_check("pwrup");

        for (int i = 0; i < 10; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

        // cmd_valid held high through a busy command with changing payload
        cyc = 0;
        while (!cmd_ready && cyc < 2000) begin @(negedge clk); cyc++; end
        tck0 = tck_cnt; sh0 = shift_n; sh_base = shift_n; pat = 16'h0;
        cmd_op = OP_DR_SCAN; cmd_len = 5'd4; cmd_data = 16'h0009; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_op = OP_IR_SCAN; cmd_data = 16'h0006; cmd_len = 5'd7;
        rsps = 0; cyc = 0;
        while (rsps == 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) begin rsps++; cmd_valid = 1'b0; end
        end
        cmd_valid = 1'b0;
        repeat (10) begin @(negedge clk); if (rsp_valid) rsps++; end
        chk("hold one rsp", rsps, 1);
        chk("hold tck count", tck_cnt - tck0, 9);
        tdiw = '0;
        for (int k = 0; k < shift_n - sh0 && k < 16; k++) tdiw[k] = tdi_hist[(sh0 + k) % 4096];
        chk("hold tdi bits", tdiw, 16'h0009);
        chk("hold idle ready", cmd_ready, 1);
        chk("hold idle busy", busy, 0);

        // asynchronous reset in the middle of a DR shift
        sh0 = shift_n; sh_base = shift_n; pat = 16'h0;
        cmd_op = OP_DR_SCAN; cmd_len = 5'd16; cmd_data = 16'hFFFF; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 0;
        while (!(st == TAP_SHIFT_DR && shift_n - sh0 >= 3) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("midreset reached shift", (st == TAP_SHIFT_DR), 1);
        rst_n = 1'b0;
        #1;
        reset_vals("midreset");
        rsps = 0;
        repeat (3) begin @(negedge clk); if (rsp_valid) rsps++; end
        chk("midreset no rsp", rsps, 0);
        release_and_check("midreset");
        run_cmd(vecs[3], "recover");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
